// File: rtl/axi_read_arbiter_pkg.sv
// Shared definitions for the two-master AXI read arbiter.
//   - AXI encodings reused by the cache refill engines
//   - arbiter FSM state type and requester count
//   - burst-length consistency helper used by the length checker
package axi_read_arbiter_pkg;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam int ARB_NUM_REQ = 2;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_AR   = 2'b01,
        ARB_R    = 2'b10
    } arb_state_t;

    // A handshaked beat is inconsistent when rlast does not coincide with the
    // beat whose zero-based index equals the accepted arlen.
    function automatic logic len_mismatch(input logic       last,
                                          input logic [7:0] cnt,
                                          input logic [7:0] len);
        logic bad;
        if (last) begin
            bad = (cnt != len);
        end else begin
            bad = (cnt == len);
        end
        return bad;
    endfunction

endpackage

// File: rtl/axi_read_if.sv
// AXI read-channel bundle (AR + R) shared by caches, arbiter and memory port.
//   master : drives the address channel and rready
//   self   : the responding side; drives arready and the R channel
interface axi_read_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  rready;
    logic                  rlast;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rvalid, rlast
    );

    modport self (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rvalid, rlast
    );
endinterface

// File: rtl/axi_read_arbiter_rr_arbiter2.sv
// Two-way request picker: round-robin (PRIO_MODE=0) or fixed priority with
// requester 0 winning (PRIO_MODE=1).
//   clk, rst : clock, asynchronous active-high reset
//   req      : request vector {s1, s0}
//   advance  : pulses when the current owner finishes its burst
//   owner    : one-hot owner of the burst that is finishing
//   pick     : one-hot winner among the current requests (combinational)
module rr_arbiter2 #(
    parameter int PRIO_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic [1:0] owner,
    output logic [1:0] pick
);

    // ptr_r = 0 favours s0 on a tie, 1 favours s1.
    logic ptr_r;

    // Winner selection; a lone requester wins regardless of the pointer.
    always_comb begin
        pick = 2'b00;
        if (PRIO_MODE == 1) begin
            if (req[0]) begin
                pick = 2'b01;
            end else if (req[1]) begin
                pick = 2'b10;
            end else begin
                pick = 2'b00;
            end
        end else begin
            case (req)
                2'b01:   pick = 2'b01;
                2'b10:   pick = 2'b10;
                2'b11:   pick = ptr_r ? 2'b10 : 2'b01;
                default: pick = 2'b00;
            endcase
        end
    end

    // After a completed burst the tie preference moves to the other requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= 1'b0;
        end else if (advance && (PRIO_MODE == 0)) begin
            ptr_r <= (owner == 2'b01);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one memory-side AXI read port between two read masters (s0 = icache,
// s1 = dcache). One whole burst per grant; the grant is held from address
// accept until the rlast beat handshakes.
//   clk, rst : clock, asynchronous active-high reset
//   s0_if    : requester 0 (responding side of the bundle)
//   s1_if    : requester 1 (responding side of the bundle)
//   m_if     : memory-side read port (driving side of the bundle)
//   grant_o  : one-hot current owner, 0 when idle
//   busy_o   : high while an address or data phase is in progress
//   err_o    : sticky rlast/arlen inconsistency flag
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int PRIO_MODE  = 0,
    parameter int LEN_CHECK  = 1
) (
    input  logic       clk,
    input  logic       rst,
    axi_read_if.self   s0_if,
    axi_read_if.self   s1_if,
    axi_read_if.master m_if,
    output logic [1:0] grant_o,
    output logic       busy_o,
    output logic       err_o
);

    arb_state_t            state_r;
    logic [1:0]            grant_r;
    logic [7:0]            len_r;
    logic [7:0]            beat_cnt_r;
    logic                  err_r;

    logic [1:0]            req_s;
    logic [1:0]            pick_s;
    logic                  ar_phase_s;
    logic                  r_phase_s;
    logic                  ar_hs_s;
    logic                  beat_s;
    logic                  last_s;
    logic [ADDR_WIDTH-1:0] m_araddr_s;
    logic [7:0]            m_arlen_s;
    logic [2:0]            m_arsize_s;
    logic [1:0]            m_arburst_s;
    logic                  m_arvalid_s;
    logic                  m_rready_s;

    assign req_s      = {s1_if.arvalid, s0_if.arvalid};
    assign ar_phase_s = (state_r == ARB_AR);
    assign r_phase_s  = (state_r == ARB_R);
    assign ar_hs_s    = ar_phase_s && m_arvalid_s && m_if.arready;
    assign beat_s     = r_phase_s && m_if.rvalid && m_rready_s;
    assign last_s     = beat_s && m_if.rlast;

    rr_arbiter2 #(
        .PRIO_MODE (PRIO_MODE)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_s),
        .advance (last_s),
        .owner   (grant_r),
        .pick    (pick_s)
    );

    // Address-channel mux: only the granted requester reaches memory, and only
    // during the address phase, so m_if is quiet in every other state.
    always_comb begin
        m_araddr_s  = {ADDR_WIDTH{1'b0}};
        m_arlen_s   = 8'd0;
        m_arsize_s  = 3'd0;
        m_arburst_s = 2'd0;
        m_arvalid_s = 1'b0;
        if (ar_phase_s && grant_r[1]) begin
            m_araddr_s  = s1_if.araddr;
            m_arlen_s   = s1_if.arlen;
            m_arsize_s  = s1_if.arsize;
            m_arburst_s = s1_if.arburst;
            m_arvalid_s = s1_if.arvalid;
        end else if (ar_phase_s && grant_r[0]) begin
            m_araddr_s  = s0_if.araddr;
            m_arlen_s   = s0_if.arlen;
            m_arsize_s  = s0_if.arsize;
            m_arburst_s = s0_if.arburst;
            m_arvalid_s = s0_if.arvalid;
        end else begin
            m_arvalid_s = 1'b0;
        end
    end

    assign m_rready_s = r_phase_s && (grant_r[1] ? s1_if.rready : s0_if.rready);

    assign m_if.araddr  = m_araddr_s;
    assign m_if.arlen   = m_arlen_s;
    assign m_if.arsize  = m_arsize_s;
    assign m_if.arburst = m_arburst_s;
    assign m_if.arvalid = m_arvalid_s;
    assign m_if.rready  = m_rready_s;

    // Return paths: the loser always sees an idle, zeroed channel.
    assign s0_if.arready = ar_phase_s && grant_r[0] && m_if.arready;
    assign s1_if.arready = ar_phase_s && grant_r[1] && m_if.arready;
    assign s0_if.rvalid  = r_phase_s && grant_r[0] && m_if.rvalid;
    assign s1_if.rvalid  = r_phase_s && grant_r[1] && m_if.rvalid;
    assign s0_if.rlast   = r_phase_s && grant_r[0] && m_if.rlast;
    assign s1_if.rlast   = r_phase_s && grant_r[1] && m_if.rlast;
    assign s0_if.rdata   = (r_phase_s && grant_r[0]) ? m_if.rdata : {DATA_WIDTH{1'b0}};
    assign s1_if.rdata   = (r_phase_s && grant_r[1]) ? m_if.rdata : {DATA_WIDTH{1'b0}};

    // Arbitration FSM; grant_r doubles as the registered grant_o and is
    // cleared whenever the FSM returns to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ARB_IDLE;
            grant_r    <= 2'b00;
            len_r      <= 8'd0;
            beat_cnt_r <= 8'd0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (|req_s) begin
                        grant_r <= pick_s;
                        state_r <= ARB_AR;
                    end else begin
                        grant_r <= 2'b00;
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_AR: begin
                    if (ar_hs_s) begin
                        len_r      <= m_arlen_s;
                        beat_cnt_r <= 8'd0;
                        state_r    <= ARB_R;
                    end else if (!m_arvalid_s) begin
                        // Withdrawn request: give up the grant, pointer untouched.
                        grant_r <= 2'b00;
                        state_r <= ARB_IDLE;
                    end else begin
                        state_r <= ARB_AR;
                    end
                end
                ARB_R: begin
                    if (beat_s) begin
                        beat_cnt_r <= beat_cnt_r + 8'd1;
                    end
                    if (last_s) begin
                        grant_r <= 2'b00;
                        state_r <= ARB_IDLE;
                    end
                end
                default: begin
                    grant_r <= 2'b00;
                    state_r <= ARB_IDLE;
                end
            endcase
        end
    end

    generate
        if (LEN_CHECK != 0) begin : g_len_chk
            // Sticky flag for an early or missing rlast; the FSM still exits on rlast.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    err_r <= 1'b0;
                end else if (beat_s && len_mismatch(m_if.rlast, beat_cnt_r, len_r)) begin
                    err_r <= 1'b1;
                end else begin
                    err_r <= err_r;
                end
            end
        end else begin : g_no_chk
            assign err_r = 1'b0;
        end
    endgenerate

    assign grant_o = grant_r;
    assign busy_o  = (state_r != ARB_IDLE);
    assign err_o   = err_r;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized self-checking bench for axi_read_arbiter.
// Two requesters issue random bursts (occasionally withdrawing before accept),
// a memory model responds with random arready/rvalid gaps and occasionally a
// wrong rlast position. A transaction-level reference (owner, phase, tie
// preference, expected beat data) predicts every visible output each cycle.
// A second instance in fixed-priority mode is exercised at the end.
module tb_axi_read_arbiter;
    import axi_read_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_read_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s0 ();
    axi_read_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s1 ();
    axi_read_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mm ();
    axi_read_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) p0 ();
    axi_read_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) p1 ();
    axi_read_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) pm ();

    logic [1:0] grant, pgrant;
    logic       busy, err, pbusy, perr;

    axi_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIO_MODE(0), .LEN_CHECK(1)) dut (
        .clk(clk), .rst(rst), .s0_if(s0), .s1_if(s1), .m_if(mm),
        .grant_o(grant), .busy_o(busy), .err_o(err)
    );

    axi_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIO_MODE(1), .LEN_CHECK(1)) dut_prio (
        .clk(clk), .rst(rst), .s0_if(p0), .s1_if(p1), .m_if(pm),
        .grant_o(pgrant), .busy_o(pbusy), .err_o(perr)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_data(input logic [31:0] a, input int k);
        return a ^ (32'h5A00_0000 + 32'(k) * 32'h0001_0101);
    endfunction

    // Reference state: phase 0 = idle, 1 = address, 2 = data.
    int          ph, own, pref, beat, blen, mcnt;
    bit          merr;
    logic [31:0] maddr;
    int          rq_st[2];      // 0 quiet, 1 requesting, 2 waiting for data
    logic [31:0] rq_addr[2];
    logic [7:0]  rq_len[2];
    int          rq_beat[2];
    bit          av[2], rr[2];
    bit          arr, rv, rl;
    logic [31:0] rd;

    task automatic model_reset();
        ph = 0; own = -1; pref = 0; merr = 1'b0; beat = 0; blen = 0; mcnt = 1; maddr = 32'd0;
        for (int i = 0; i < 2; i++) begin
            rq_st[i] = 0; rq_addr[i] = 32'd0; rq_len[i] = 8'd0; rq_beat[i] = 0;
            av[i] = 1'b0; rr[i] = 1'b0;
        end
        arr = 1'b0; rv = 1'b0; rl = 1'b0; rd = 32'd0;
    endtask

    task automatic apply_main();
        s0.araddr = rq_addr[0]; s0.arlen = rq_len[0]; s0.arsize = AXI_SIZE_4B;
        s0.arburst = AXI_BURST_INCR; s0.arvalid = av[0]; s0.rready = rr[0];
        s1.araddr = rq_addr[1]; s1.arlen = rq_len[1]; s1.arsize = AXI_SIZE_4B;
        s1.arburst = AXI_BURST_INCR; s1.arvalid = av[1]; s1.rready = rr[1];
        mm.arready = arr; mm.rvalid = rv; mm.rlast = rl; mm.rdata = rd;
    endtask

    task automatic drive_prio(input bit a0, input bit a1, input logic [31:0] data);
        p0.araddr = 32'h100; p0.arlen = 8'd0; p0.arsize = AXI_SIZE_4B; p0.arburst = AXI_BURST_INCR;
        p0.arvalid = a0; p0.rready = 1'b1;
        p1.araddr = 32'h200; p1.arlen = 8'd0; p1.arsize = AXI_SIZE_4B; p1.arburst = AXI_BURST_INCR;
        p1.arvalid = a1; p1.rready = 1'b1;
        pm.arready = 1'b1; pm.rvalid = 1'b1; pm.rlast = 1'b1; pm.rdata = data;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 2; i++) begin
            if (rq_st[i] == 0 && ($urandom % 2) == 0) begin
                rq_st[i]   = 1;
                rq_addr[i] = $urandom() & 32'hFFFF_FFE0;
                rq_len[i]  = 8'($urandom_range(0, 7));
            end else if (rq_st[i] == 1 && ($urandom % 32) == 0) begin
                rq_st[i] = 0;
            end
            av[i] = (rq_st[i] == 1);
            rr[i] = (($urandom % 5) != 0);
        end
        arr = (($urandom % 2) == 0);
        if (ph == 2) begin
            rv = (($urandom % 4) != 0);
            rd = beat_data(maddr, beat);
            rl = (beat == mcnt - 1);
        end else begin
            rv = 1'b0; rd = 32'd0; rl = 1'b0;
        end
        apply_main();
    endtask

    task automatic check_reset();
        check_val("rst_grant", grant, 2'b00);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_err", err, 1'b0);
        check_val("rst_m_arvalid", mm.arvalid, 1'b0);
        check_val("rst_m_rready", mm.rready, 1'b0);
        check_val("rst_m_araddr", mm.araddr, 32'd0);
        check_val("rst_s0_arready", s0.arready, 1'b0);
        check_val("rst_s1_arready", s1.arready, 1'b0);
        check_val("rst_s0_rvalid", s0.rvalid, 1'b0);
        check_val("rst_s1_rvalid", s1.rvalid, 1'b0);
        check_val("rst_s0_rlast", s0.rlast, 1'b0);
        check_val("rst_s1_rlast", s1.rlast, 1'b0);
        check_val("rst_s0_rdata", s0.rdata, 32'd0);
        check_val("rst_s1_rdata", s1.rdata, 32'd0);
    endtask

    task automatic check_outputs();
        logic [1:0]  eg;
        bit          o_ar[2], o_rv[2], o_rl[2];
        logic [31:0] o_rd[2];
        bit          w;
        eg = (own < 0) ? 2'b00 : (2'b01 << own);
        check_val("grant", grant, eg);
        check_val("busy", busy, (ph != 0));
        check_val("err", err, merr);
        if (ph == 1) begin
            check_val("m_arvalid", mm.arvalid, av[own]);
            check_val("m_araddr", mm.araddr, rq_addr[own]);
            check_val("m_arlen", mm.arlen, rq_len[own]);
        end else begin
            check_val("m_arvalid", mm.arvalid, 1'b0);
        end
        check_val("m_rready", mm.rready, (ph == 2) ? rr[own] : 1'b0);
        o_ar[0] = s0.arready; o_rv[0] = s0.rvalid; o_rl[0] = s0.rlast; o_rd[0] = s0.rdata;
        o_ar[1] = s1.arready; o_rv[1] = s1.rvalid; o_rl[1] = s1.rlast; o_rd[1] = s1.rdata;
        for (int i = 0; i < 2; i++) begin
            w = (i == own);
            check_val($sformatf("s%0d_arready", i), o_ar[i], (ph == 1 && w) ? arr : 1'b0);
            check_val($sformatf("s%0d_rvalid", i), o_rv[i], (ph == 2 && w) ? rv : 1'b0);
            check_val($sformatf("s%0d_rlast", i), o_rl[i], (ph == 2 && w) ? rl : 1'b0);
            check_val($sformatf("s%0d_rdata", i), o_rd[i],
                      (ph == 2 && w) ? beat_data(rq_addr[i], rq_beat[i]) : 32'd0);
        end
    endtask

    task automatic model_step();
        bit last;
        case (ph)
            0: begin
                if (av[0] || av[1]) begin
                    if (av[0] && av[1]) own = pref;
                    else own = av[0] ? 0 : 1;
                    ph = 1;
                end
            end
            1: begin
                if (!av[own]) begin
                    ph = 0; own = -1;
                end else if (arr) begin
                    ph = 2; blen = int'(rq_len[own]); beat = 0; maddr = rq_addr[own];
                    mcnt = (($urandom % 8) == 0) ? 1 + int'($urandom % 10) : blen + 1;
                    rq_st[own] = 2; rq_beat[own] = 0;
                end
            end
            2: begin
                if (rv && rr[own]) begin
                    last = (beat == mcnt - 1);
                    if ((last && beat != blen) || (!last && beat == blen)) merr = 1'b1;
                    beat++;
                    rq_beat[own]++;
                    if (last) begin
                        rq_st[own] = 0; pref = 1 - own; own = -1; ph = 0;
                    end
                end
            end
            default: ph = 0;
        endcase
    endtask

    initial begin
        bit         did_rst;
        bit         pav0, prev_av0, acc0;
        logic [1:0] pgrant_prev;
        int         s0_wins, s1_wins;

        model_reset();
        apply_main();
        drive_prio(1'b0, 1'b0, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_reset();
        check_val("rst_prio_grant", pgrant, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        did_rst = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!did_rst && cyc > 2000 && ph == 2 && beat >= 1) begin
                // Asynchronous reset in the middle of a data phase.
                did_rst = 1'b1;
                #2;
                rst = 1'b1;
                #1;
                check_reset();
                model_reset();
                apply_main();
                @(negedge clk);
                rst = 1'b0;
            end
            drive_inputs();
            #1;
            check_outputs();
            model_step();
            @(negedge clk);
        end
        check_val("rst_mid_burst_seen", did_rst, 1'b1);

        // Fixed-priority instance: s1 requests continuously, s0 mostly.
        model_reset();
        apply_main();
        pav0 = 1'b1; prev_av0 = 1'b0; pgrant_prev = 2'b00; s0_wins = 0; s1_wins = 0;
        for (int c = 0; c < 300; c++) begin
            drive_prio(pav0, 1'b1, 32'(c));
            #1;
            if (pgrant_prev == 2'b00 && pgrant != 2'b00) begin
                check_val("prio_pick", pgrant, prev_av0 ? 2'b01 : 2'b10);
                if (pgrant == 2'b01) s0_wins++;
                else s1_wins++;
            end
            prev_av0    = pav0;
            pgrant_prev = pgrant;
            acc0        = p0.arready;
            if (pav0 && acc0) pav0 = (($urandom % 3) == 0);
            else if (!pav0) pav0 = (($urandom % 2) == 0);
            @(negedge clk);
        end
        check_val("prio_s0_won", (s0_wins > 0), 1'b1);
        check_val("prio_s1_window", (s1_wins > 0), 1'b1);
        check_val("prio_err", perr, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
